ft60x_bus_ctrl: RTL and testbench

Parametrised bus master for the FT600/FT601 245 synchronous FIFO interface. It replaces the fixed-width test path with a width-generic controller, 16 bit (FT600) or 32 bit (FT601). It arbitrates host-to-FPGA reads (RX) against FPGA-to-host writes (TX) in bounded, fairly alternated bursts. It presents the user side as valid/ready streams, with an internal RX FIFO that absorbs pipeline overrun. It sits between the pad-level top (which owns the inout tristates) and the test/traffic logic.

---
 rtl/ft60x_pkg.sv | 19 +
 rtl/ft60x_sync_fifo.sv | 43 ++++
 rtl/ft60x_bus_ctrl.sv | 132 +++++++++++++
 tb/tb_ft60x_bus_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ft60x_pkg.sv
// ft60x_pkg: FSM state encoding and bus-width helpers shared by the FT60x bus controller
package ft60x_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_OE    = 3'd1,
    RX_READ  = 3'd2,
    RX_END   = 3'd3,
    TX_WRITE = 3'd4,
    TX_END   = 3'd5
  } ftState;
  localparam int FT600_D_BIT = 16;
  localparam int FT601_D_BIT = 32;
  function automatic int beBit(input int dBit);
    return dBit / 8;
  endfunction
  function automatic logic legalWidth(input int dBit);
    return dBit == FT600_D_BIT || dBit == FT601_D_BIT;
  endfunction
endpackage

// File: rtl/ft60x_sync_fifo.sv
// ft60x_sync_fifo: first-word-fall-through FIFO with occupancy count and sticky overflow
module ft60x_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wrEn,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     rdEn,
  output logic [WIDTH-1:0]         rdData,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0] cnt;
  logic full, doPush, doPop;
  assign full = cnt == FULL_CNT;
  assign empty = cnt == '0;
  assign doPop = rdEn && !empty;
  // a pop in the same cycle frees the slot, so a push at full is still legal
  assign doPush = wrEn && (!full || doPop);
  assign rdData = mem[rdPtr];
  assign count = cnt;
  always_ff @(posedge clk)
    if (doPush) mem[wrPtr] <= wrData;
  always_ff @(posedge clk)
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      wrPtr <= doPush ? wrPtr + 1'b1 : wrPtr;
      rdPtr <= doPop ? rdPtr + 1'b1 : rdPtr;
      cnt <= cnt + (AW+1)'(doPush) - (AW+1)'(doPop);
      ovf <= ovf || (wrEn && !doPush);
    end
endmodule

// File: rtl/ft60x_bus_ctrl.sv
// ft60x_bus_ctrl: width-generic FT600/FT601 245 sync FIFO bus master with fair RX/TX bursts.
// Define FT60X_LOOPBACK_EN to echo received host data straight back to the host.
module ft60x_bus_ctrl import ft60x_pkg::*; #(
  parameter int D_BIT     = 16,
  parameter int BE_BIT    = beBit(D_BIT),
  parameter int RX_DEPTH  = 16,
  parameter int RX_MARGIN = 4,
  parameter int MAX_BURST = 256
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic [D_BIT-1:0]  iDATA,
  input  logic [BE_BIT-1:0] iBE,
  output logic [D_BIT-1:0]  oDATA,
  output logic [BE_BIT-1:0] oBE,
  output logic              oDATA_OE,
  input  logic              iTXE_N,
  input  logic              iRXF_N,
  output logic              oOE_N,
  output logic              oRD_N,
  output logic              oWR_N,
  output logic [D_BIT-1:0]  oRX_DATA,
  output logic [BE_BIT-1:0] oRX_BE,
  output logic              oRX_VALID,
  input  logic              iRX_READY,
  input  logic [D_BIT-1:0]  iTX_DATA,
  input  logic [BE_BIT-1:0] iTX_BE,
  input  logic              iTX_VALID,
  output logic              oTX_READY,
  output logic [2:0]        oSTATE,
  output logic              oRX_OVF
);
  if (!legalWidth(D_BIT) || BE_BIT != beBit(D_BIT)) begin : gBadWidth
    $error("ft60x_bus_ctrl: D_BIT must be 16 or 32 with BE_BIT = D_BIT/8");
  end
  localparam int CW = $clog2(RX_DEPTH) + 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RX_DEPTH);
  localparam logic [CW-1:0] MARGIN_C = CW'(RX_MARGIN);
  localparam logic [BW-1:0] LAST_C = BW'(MAX_BURST - 1);
  ftState state, nextState;
  logic lastTx;
  logic [BW-1:0] burstCnt;
  logic holdValid, nextHoldValid;
  logic [D_BIT-1:0] holdData;
  logic [BE_BIT-1:0] holdBe;
  logic push, accept, txReady, load, rxReq, txReq, burstDone, rxLow, pop;
  logic txSrcValid;
  logic [D_BIT-1:0] txSrcData;
  logic [BE_BIT-1:0] txSrcBe;
  logic [CW-1:0] fifoCount, freeNow;
  logic fifoEmpty;
  logic [D_BIT+BE_BIT-1:0] fifoOut;
  ft60x_sync_fifo #(.WIDTH(D_BIT + BE_BIT), .DEPTH(RX_DEPTH)) rxFifo (
    .clk(iCLK),
    .rst(iRESET),
    .wrEn(push),
    .wrData({iBE, iDATA}),
    .rdEn(pop),
    .rdData(fifoOut),
    .empty(fifoEmpty),
    .count(fifoCount),
    .ovf(oRX_OVF)
  );
  assign push = !oRD_N && !iRXF_N;
  assign accept = !oWR_N && !iTXE_N;
  assign freeNow = DEPTH_C - fifoCount;
  // look one word ahead: the strobe stays low for one more edge if we do not leave now
  assign rxLow = freeNow < MARGIN_C + CW'(push);
  assign burstDone = (push || accept) && burstCnt == LAST_C;
  assign txReady = state == TX_WRITE && (!holdValid || accept);
  assign load = txSrcValid && txReady;
  assign nextHoldValid = load || (holdValid && !accept);
  assign rxReq = !iRXF_N && freeNow >= MARGIN_C;
  assign txReq = !iTXE_N && (txSrcValid || holdValid);
`ifdef FT60X_LOOPBACK_EN
  logic unusedUser;
  assign unusedUser = ^{iTX_DATA, iTX_BE, iTX_VALID, iRX_READY};
  assign txSrcValid = !fifoEmpty;
  assign {txSrcBe, txSrcData} = fifoOut;
  assign pop = load;
  assign oRX_VALID = 1'b0;
  assign oTX_READY = 1'b0;
`else
  assign txSrcValid = iTX_VALID;
  assign txSrcData = iTX_DATA;
  assign txSrcBe = iTX_BE;
  assign oRX_VALID = !fifoEmpty;
  assign pop = oRX_VALID && iRX_READY;
  assign oTX_READY = txReady;
`endif
  assign {oRX_BE, oRX_DATA} = fifoOut;
  assign oDATA = holdData;
  assign oBE = holdBe;
  assign oSTATE = state;
  always_comb begin
    nextState = state;
    case (state)
      IDLE:     nextState = (rxReq && (!txReq || lastTx)) ? RX_OE : txReq ? TX_WRITE : IDLE;
      RX_OE:    nextState = RX_READ;
      RX_READ:  nextState = (iRXF_N || burstDone || rxLow) ? RX_END : RX_READ;
      RX_END:   nextState = IDLE;
      TX_WRITE: nextState = (iTXE_N || burstDone || !nextHoldValid) ? TX_END : TX_WRITE;
      TX_END:   nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end
  always_ff @(posedge iCLK)
    if (iRESET) begin
      state <= IDLE;
      lastTx <= 1'b1;
      burstCnt <= '0;
      holdValid <= 1'b0;
      holdData <= '0;
      holdBe <= '0;
      oOE_N <= 1'b1;
      oRD_N <= 1'b1;
      oWR_N <= 1'b1;
      oDATA_OE <= 1'b0;
    end else begin
      state <= nextState;
      lastTx <= (state == IDLE && nextState != IDLE) ? nextState == TX_WRITE : lastTx;
      burstCnt <= state == IDLE ? '0 : burstCnt + BW'(push || accept);
      holdValid <= nextHoldValid;
      holdData <= load ? txSrcData : holdData;
      holdBe <= load ? txSrcBe : holdBe;
      oOE_N <= !(nextState == RX_OE || nextState == RX_READ);
      oRD_N <= nextState != RX_READ;
      oWR_N <= !(nextState == TX_WRITE && nextHoldValid);
      oDATA_OE <= nextState == TX_WRITE || nextState == TX_END;
    end
endmodule

// File: tb/tb_ft60x_bus_ctrl.sv
// tb_ft60x_bus_ctrl: directed bench with a small FT60x host model driving ft60x_bus_ctrl
module tb_ft60x_bus_ctrl;
  logic iCLK = 1'b0;
  logic iRESET = 1'b1;
  logic [15:0] iDATA, oDATA, oRX_DATA, iTX_DATA;
  logic [1:0] iBE, oBE, oRX_BE, iTX_BE;
  logic oDATA_OE, iTXE_N, iRXF_N, oOE_N, oRD_N, oWR_N;
  logic oRX_VALID, iRX_READY, iTX_VALID, oTX_READY, oRX_OVF;
  logic [2:0] oSTATE;
  int tests = 0, failures = 0;
  logic [15:0] hostRx[$], hostLog[$], rxLog[$], txQ[$];
  int bursts[$];
  int txIdx = 0, txeBlock = 0, txeStopAt = 0, rdCnt = 0, contErr = 0, gapErr = 0, beErr = 0;
  int curDir = 0, curLen = 0, lastDirB = 0;
  bit txPause = 0, rxReady = 1, relSeen = 0;
  always #5 iCLK = ~iCLK;
  ft60x_bus_ctrl #(.D_BIT(16), .BE_BIT(2), .RX_DEPTH(16), .RX_MARGIN(4), .MAX_BURST(4)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iDATA(iDATA), .iBE(iBE), .oDATA(oDATA), .oBE(oBE),
    .oDATA_OE(oDATA_OE), .iTXE_N(iTXE_N), .iRXF_N(iRXF_N), .oOE_N(oOE_N), .oRD_N(oRD_N),
    .oWR_N(oWR_N), .oRX_DATA(oRX_DATA), .oRX_BE(oRX_BE), .oRX_VALID(oRX_VALID),
    .iRX_READY(iRX_READY), .iTX_DATA(iTX_DATA), .iTX_BE(iTX_BE), .iTX_VALID(iTX_VALID),
    .oTX_READY(oTX_READY), .oSTATE(oSTATE), .oRX_OVF(oRX_OVF)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive();
    iRXF_N = hostRx.size() == 0;
    iDATA = '0;
    if (hostRx.size() != 0) iDATA = hostRx[0];
    iBE = 2'b11;
    iTXE_N = txeBlock != 0;
    iTX_VALID = !txPause && txIdx < txQ.size();
    iTX_DATA = '0;
    if (iTX_VALID) iTX_DATA = txQ[txIdx];
    iTX_BE = 2'b11;
    iRX_READY = rxReady;
  endtask
  task automatic clearLogs();
    hostRx.delete(); hostLog.delete(); rxLog.delete(); txQ.delete(); bursts.delete();
    txIdx = 0; rdCnt = 0; curLen = 0; lastDirB = 0; txeStopAt = 0; txeBlock = 0;
  endtask
  task automatic doReset();
    iRESET = 1'b1;
    repeat (2) @(posedge iCLK);
    #2 iRESET = 1'b0;
  endtask
  // host side of the bus plus the user-stream sinks/sources
  initial begin
    bit rd, wr, uRx, uTx, rel;
    logic [15:0] wd, ud;
    int dir;
    forever begin
      @(negedge iCLK);
      rd = !oRD_N && !iRXF_N;
      wr = !oWR_N && !iTXE_N;
      wd = oDATA;
      uRx = oRX_VALID && iRX_READY;
      ud = oRX_DATA;
      uTx = iTX_VALID && oTX_READY;
      if (oDATA_OE && !oOE_N) contErr++;
      if (uRx && oRX_BE != 2'b11) beErr++;
      rel = !oDATA_OE && oOE_N;
      @(posedge iCLK);
      #1;
      dir = rd ? 1 : wr ? 2 : 0;
      if (dir != 0) begin
        if (curLen == 0 && lastDirB != 0 && lastDirB != dir && !relSeen) gapErr++;
        curDir = dir;
        curLen++;
        relSeen = 0;
      end else begin
        if (curLen != 0) begin
          bursts.push_back(curDir * 256 + curLen);
          lastDirB = curDir;
          curLen = 0;
        end
        if (rel) relSeen = 1;
      end
      if (rd) begin
        void'(hostRx.pop_front());
        rdCnt++;
      end
      if (wr) begin
        hostLog.push_back(wd);
        if (hostLog.size() == txeStopAt) txeBlock = 10;
      end
      if (uRx) rxLog.push_back(ud);
      if (uTx) txIdx++;
      if (txeBlock > 0) txeBlock--;
      drive();
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int err;
    drive();
    repeat (3) @(posedge iCLK);
    #2;
    check("rst_oe_n", oOE_N, 1);
    check("rst_rd_n", oRD_N, 1);
    check("rst_wr_n", oWR_N, 1);
    check("rst_data_oe", oDATA_OE, 0);
    check("rst_data", {oBE, oDATA}, 0);
    check("rst_rx_valid", oRX_VALID, 0);
    check("rst_tx_ready", oTX_READY, 0);
    check("rst_ovf", oRX_OVF, 0);
    check("rst_state", oSTATE, 0);
    iRESET = 1'b0;
`ifdef FT60X_LOOPBACK_EN
    hostRx.push_back(16'hA5A5);
    hostRx.push_back(16'h5A5A);
    drive();
    for (int c = 0; c < 300 && hostLog.size() < 2; c++) begin @(posedge iCLK); #2; end
    check("lb_count", hostLog.size(), 2);
    check("lb_word0", hostLog.size() > 0 ? hostLog[0] : 16'hxxxx, 16'hA5A5);
    check("lb_word1", hostLog.size() > 1 ? hostLog[1] : 16'hxxxx, 16'h5A5A);
    check("lb_rx_valid", oRX_VALID, 0);
`else
    for (int i = 1; i <= 10; i++) hostRx.push_back(16'(i));
    drive();
    for (int c = 0; c < 300 && rxLog.size() < 10; c++) begin @(posedge iCLK); #2; end
    repeat (5) @(posedge iCLK);
    #2;
    check("rx10_count", rxLog.size(), 10);
    for (int i = 0; i < 10; i++)
      check($sformatf("rx10_word%0d", i), i < rxLog.size() ? rxLog[i] : 16'hxxxx, 16'(i + 1));
    check("rx10_be", beErr, 0);
    check("rx10_ovf", oRX_OVF, 0);
    check("rx10_bursts", bursts.size(), 3);
    check("rx10_b2", bursts.size() > 2 ? bursts[2] : -1, 32'h102);
    doReset();
    clearLogs();
    for (int i = 1; i <= 8; i++) begin
      hostRx.push_back(16'h100 + 16'(i));
      txQ.push_back(16'h200 + 16'(i));
    end
    drive();
    for (int c = 0; c < 500 && (hostLog.size() < 8 || rxLog.size() < 8); c++) begin @(posedge iCLK); #2; end
    repeat (5) @(posedge iCLK);
    #2;
    check("alt_tx_count", hostLog.size(), 8);
    check("alt_rx_count", rxLog.size(), 8);
    err = 0;
    for (int i = 0; i < 8; i++) begin
      if (i >= hostLog.size() || hostLog[i] !== 16'h200 + 16'(i + 1)) err++;
      if (i >= rxLog.size() || rxLog[i] !== 16'h100 + 16'(i + 1)) err++;
    end
    check("alt_data_err", err, 0);
    check("alt_bursts", bursts.size(), 4);
    check("alt_b0", bursts.size() > 0 ? bursts[0] : -1, 32'h104);
    check("alt_b1", bursts.size() > 1 ? bursts[1] : -1, 32'h204);
    check("alt_b2", bursts.size() > 2 ? bursts[2] : -1, 32'h104);
    check("alt_b3", bursts.size() > 3 ? bursts[3] : -1, 32'h204);
    check("alt_gap", gapErr, 0);
    doReset();
    clearLogs();
    for (int i = 1; i <= 6; i++) txQ.push_back(16'h300 + 16'(i));
    txeStopAt = 3;
    drive();
    for (int c = 0; c < 400 && hostLog.size() < 6; c++) begin @(posedge iCLK); #2; end
    repeat (5) @(posedge iCLK);
    #2;
    check("txe_count", hostLog.size(), 6);
    err = 0;
    for (int i = 0; i < 6; i++)
      if (i >= hostLog.size() || hostLog[i] !== 16'h300 + 16'(i + 1)) err++;
    check("txe_data_err", err, 0);
    check("txe_b0", bursts.size() > 0 ? bursts[0] : -1, 32'h203);
    check("txe_b1", bursts.size() > 1 ? bursts[1] : -1, 32'h203);
    doReset();
    clearLogs();
    rxReady = 0;
    for (int i = 1; i <= 40; i++) hostRx.push_back(16'h400 + 16'(i));
    drive();
    repeat (150) @(posedge iCLK);
    #2;
    check("fill_range", rdCnt >= 12 && rdCnt <= 16, 1);
    check("fill_ovf", oRX_OVF, 0);
    check("fill_valid", oRX_VALID, 1);
    check("fill_head", oRX_DATA, 16'h401);
    rxReady = 1;
    drive();
    for (int c = 0; c < 800 && rxLog.size() < 40; c++) begin @(posedge iCLK); #2; end
    check("drain_count", rxLog.size(), 40);
    err = 0;
    for (int i = 0; i < 40; i++)
      if (i >= rxLog.size() || rxLog[i] !== 16'h400 + 16'(i + 1)) err++;
    check("drain_order", err, 0);
    check("drain_ovf", oRX_OVF, 0);
    doReset();
    clearLogs();
    for (int i = 1; i <= 8; i++) txQ.push_back(16'h500 + 16'(i));
    drive();
    for (int c = 0; c < 200 && hostLog.size() < 2; c++) begin @(posedge iCLK); #2; end
    iRESET = 1'b1;
    txPause = 1;
    drive();
    @(posedge iCLK);
    #2;
    check("midrst_wr_n", oWR_N, 1);
    check("midrst_data_oe", oDATA_OE, 0);
    check("midrst_state", oSTATE, 0);
    check("midrst_tx_ready", oTX_READY, 0);
    iRESET = 1'b0;
    txPause = 0;
    drive();
    for (int c = 0; c < 400 && hostLog.size() < 8; c++) begin @(posedge iCLK); #2; end
    repeat (3) @(posedge iCLK);
    #2;
    check("midrst_count", hostLog.size(), 8);
    err = 0;
    for (int i = 0; i < 8; i++)
      if (i >= hostLog.size() || hostLog[i] !== 16'h500 + 16'(i + 1)) err++;
    check("midrst_data_err", err, 0);
`endif
    check("contention", contErr, 0);
    check("gap_all", gapErr, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
